// File: rtl/t09_lcd_bus_receiver_if.sv
// Bus bundle for the 8080-style LCD write receiver: strobe/data pins plus decoded event outputs.
// frame_count is only live when T09_LCDRX_FRAMECNT_EN is defined in the receiver build.
interface t09_lcd_bus_receiver_if #(
  parameter int X_W = 9,
  parameter int Y_W = 9
);
  // Handshake: no ready/backpressure. pix_valid, cmd_valid, frame_done and proto_err are
  // single-cycle pulses; pix_x/pix_y/pix_rgb/cmd_code are valid while the matching *_valid is
  // high and hold their value until the next event. The consumer must accept every pulse.
  logic           wr;
  logic           dcx;
  logic [7:0]     D;
  logic           pix_valid;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic [15:0]    pix_rgb;
  logic           cmd_valid;
  logic [7:0]     cmd_code;
  logic           frame_done;
  logic           proto_err;
  logic [15:0]    frame_count;
  // Observation-only view of the FSM and the active window.
  logic [2:0]     dbg_state;
  logic [X_W-1:0] dbg_sc;
  logic [X_W-1:0] dbg_ec;
  logic [Y_W-1:0] dbg_sp;
  logic [Y_W-1:0] dbg_ep;

  modport master (
    output wr, dcx, D,
    input  pix_valid, pix_x, pix_y, pix_rgb, cmd_valid, cmd_code,
    input  frame_done, proto_err, frame_count,
    input  dbg_state, dbg_sc, dbg_ec, dbg_sp, dbg_ep
  );

  modport slave (
    input  wr, dcx, D,
    output pix_valid, pix_x, pix_y, pix_rgb, cmd_valid, cmd_code,
    output frame_done, proto_err, frame_count,
    output dbg_state, dbg_sc, dbg_ec, dbg_sp, dbg_ep
  );
endinterface

// File: rtl/t09_lcd_bus_receiver.sv
// 8080-style LCD write-bus receiver: decodes CASET/PASET/RAMWR into windowed RGB565 pixel events.
// Define T09_LCDRX_FRAMECNT_EN to enable the 16-bit completed-frame counter on frame_count.
module t09_lcd_bus_receiver #(
  parameter int X_W = 9,
  parameter int Y_W = 9
) (
  input  logic                   clk,
  input  logic                   nrst,
  t09_lcd_bus_receiver_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CASET = 3'd1,
    PASET = 3'd2,
    RAMWR = 3'd3,
    SKIP  = 3'd4
  } state_t;

  logic           wr_s1_q, wr_s2_q, wr_h_q;
  logic           wr_rise;
  logic           stb_q, dcx_q;
  logic [7:0]     byte_q;

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [23:0]    buf_q, buf_d;
  logic           hi_pend_q, hi_pend_d;
  logic [X_W-1:0] sc_q, sc_d, ec_q, ec_d, cx_q, cx_d;
  logic [Y_W-1:0] sp_q, sp_d, ep_q, ep_d, cy_q, cy_d;

  logic           pix_valid_q, pix_valid_d;
  logic [X_W-1:0] pix_x_q, pix_x_d;
  logic [Y_W-1:0] pix_y_q, pix_y_d;
  logic [15:0]    pix_rgb_q, pix_rgb_d;
  logic           cmd_valid_q, cmd_valid_d;
  logic [7:0]     cmd_code_q, cmd_code_d;
  logic           frame_done_q, frame_done_d;
  logic           proto_err_q, proto_err_d;

  logic [15:0]    start_w, end_w;
  logic [X_W-1:0] sx_new, ex_new;
  logic [Y_W-1:0] sy_new, ey_new;

  // Synchronizer idles high so a reset release with wr high never looks like an edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_s1_q <= 1'b1;
      wr_s2_q <= 1'b1;
      wr_h_q  <= 1'b1;
    end else begin
      wr_s1_q <= bus.wr;
      wr_s2_q <= wr_s1_q;
      wr_h_q  <= wr_s2_q;
    end
  end

  assign wr_rise = wr_s2_q & ~wr_h_q;

  // D/dcx are held stable by the host around the strobe, so they are captured unsynchronized.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stb_q  <= 1'b0;
      dcx_q  <= 1'b0;
      byte_q <= 8'h00;
    end else begin
      stb_q <= wr_rise;
      if (wr_rise) begin
        dcx_q  <= bus.dcx;
        byte_q <= bus.D;
      end
    end
  end

  // Bytes 1..3 of a CASET/PASET are shifted into buf_q; byte 4 is still in byte_q.
  assign start_w = buf_q[23:8];
  assign end_w   = {buf_q[7:0], byte_q};
  assign sx_new  = X_W'(start_w);
  assign ex_new  = X_W'(end_w);
  assign sy_new  = Y_W'(start_w);
  assign ey_new  = Y_W'(end_w);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    hi_pend_d    = hi_pend_q;
    sc_d         = sc_q;
    ec_d         = ec_q;
    sp_d         = sp_q;
    ep_d         = ep_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    pix_valid_d  = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_rgb_d    = pix_rgb_q;
    cmd_valid_d  = 1'b0;
    cmd_code_d   = cmd_code_q;
    frame_done_d = 1'b0;
    proto_err_d  = 1'b0;

    if (stb_q) begin
      if (!dcx_q) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = byte_q;
        if (((state_q == CASET) || (state_q == PASET)) && (cnt_q != 2'd0)) proto_err_d = 1'b1;
        if ((state_q == RAMWR) && hi_pend_q) proto_err_d = 1'b1;
        cnt_d     = 2'd0;
        hi_pend_d = 1'b0;
        case (byte_q)
          8'h2A: state_d = CASET;
          8'h2B: state_d = PASET;
          8'h2C: begin
            state_d = RAMWR;
            cx_d    = sc_q;
            cy_d    = sp_q;
          end
          8'h01: begin
            state_d = IDLE;
            sc_d    = '0;
            ec_d    = '1;
            sp_d    = '0;
            ep_d    = '1;
          end
          default: state_d = SKIP;
        endcase
      end else begin
        case (state_q)
          IDLE: proto_err_d = 1'b1;
          CASET, PASET: begin
            if (cnt_q != 2'd3) begin
              buf_d = {buf_q[15:0], byte_q};
              cnt_d = cnt_q + 2'd1;
            end else begin
              cnt_d   = 2'd0;
              state_d = SKIP;
              if (state_q == CASET) begin
                sc_d = sx_new;
                if (ex_new < sx_new) begin
                  ec_d        = sx_new;
                  proto_err_d = 1'b1;
                end else begin
                  ec_d = ex_new;
                end
              end else begin
                sp_d = sy_new;
                if (ey_new < sy_new) begin
                  ep_d        = sy_new;
                  proto_err_d = 1'b1;
                end else begin
                  ep_d = ey_new;
                end
              end
            end
          end
          RAMWR: begin
            if (!hi_pend_q) begin
              hi_pend_d = 1'b1;
              buf_d     = {buf_q[23:8], byte_q};
            end else begin
              hi_pend_d   = 1'b0;
              pix_valid_d = 1'b1;
              pix_x_d     = cx_q;
              pix_y_d     = cy_q;
              pix_rgb_d   = {buf_q[7:0], byte_q};
              if (cx_q == ec_q) begin
                cx_d = sc_q;
                if (cy_q == ep_q) begin
                  cy_d         = sp_q;
                  frame_done_d = 1'b1;
                end else begin
                  cy_d = cy_q + 1'b1;
                end
              end else begin
                cx_d = cx_q + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      buf_q        <= 24'h000000;
      hi_pend_q    <= 1'b0;
      sc_q         <= '0;
      ec_q         <= '1;
      sp_q         <= '0;
      ep_q         <= '1;
      cx_q         <= '0;
      cy_q         <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_rgb_q    <= 16'h0000;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= 8'h00;
      frame_done_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      hi_pend_q    <= hi_pend_d;
      sc_q         <= sc_d;
      ec_q         <= ec_d;
      sp_q         <= sp_d;
      ep_q         <= ep_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_rgb_q    <= pix_rgb_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_code_q   <= cmd_code_d;
      frame_done_q <= frame_done_d;
      proto_err_q  <= proto_err_d;
    end
  end

`ifdef T09_LCDRX_FRAMECNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = frame_done_d ? frame_cnt_q + 16'd1 : frame_cnt_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) frame_cnt_q <= 16'h0000;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign bus.frame_count = frame_cnt_q;
`else
  assign bus.frame_count = 16'h0000;
`endif

  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_x      = pix_x_q;
  assign bus.pix_y      = pix_y_q;
  assign bus.pix_rgb    = pix_rgb_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_code   = cmd_code_q;
  assign bus.frame_done = frame_done_q;
  assign bus.proto_err  = proto_err_q;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_sc     = sc_q;
  assign bus.dbg_ec     = ec_q;
  assign bus.dbg_sp     = sp_q;
  assign bus.dbg_ep     = ep_q;

endmodule

// File: tb/tb_t09_lcd_bus_receiver.sv
// Directed bench for t09_lcd_bus_receiver: 8080 byte driver, event monitor, pixel expected queue.
// Frame-count expectations follow T09_LCDRX_FRAMECNT_EN as defined for the build.
module tb_t09_lcd_bus_receiver;
  localparam int X_W = 9;
  localparam int Y_W = 9;

  logic clk;
  logic nrst;

  t09_lcd_bus_receiver_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

  t09_lcd_bus_receiver #(.X_W(X_W), .Y_W(Y_W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int perr_cnt = 0;
  logic [34:0] pix_q[$];
  logic [34:0] exp_q[$];
  logic [8:0]  cmd_q[$];

`ifdef T09_LCDRX_FRAMECNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // event monitor: samples registered outputs on the falling edge
  always @(negedge clk) begin
    if (nrst) begin
      if (bus.pix_valid) pix_q.push_back({bus.frame_done, bus.pix_x, bus.pix_y, bus.pix_rgb});
      if (bus.cmd_valid) cmd_q.push_back({bus.proto_err, bus.cmd_code});
      if (bus.proto_err) perr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] px(input logic fd, input int x, input int y, input logic [15:0] rgb);
    return {fd, X_W'(x), Y_W'(y), rgb};
  endfunction

  // driver tasks
  task automatic send_byte(input logic is_data, input logic [7:0] b);
    @(negedge clk);
    bus.wr  = 1'b0;
    bus.dcx = is_data;
    bus.D   = b;
    repeat (3) @(negedge clk);
    bus.wr = 1'b1;
    repeat (5) @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    send_byte(1'b0, b);
  endtask

  task automatic send_data(input logic [7:0] b);
    send_byte(1'b1, b);
  endtask

  task automatic send_quad(input logic [7:0] cmd, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    send_cmd(cmd);
    send_data(b0);
    send_data(b1);
    send_data(b2);
    send_data(b3);
  endtask

  task automatic clear_logs();
    pix_q.delete();
    exp_q.delete();
    cmd_q.delete();
    perr_cnt = 0;
  endtask

  // scoreboard: observed pixel events against the expected queue
  task automatic check_pixels(input string tag);
    check({tag, "_npix"}, pix_q.size(), exp_q.size());
    while (exp_q.size() > 0 && pix_q.size() > 0) check(tag, pix_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    pix_q.delete();
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: run did not complete within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    nrst    = 1'b0;
    bus.wr  = 1'b1;
    bus.dcx = 1'b1;
    bus.D   = 8'h00;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_pix_valid", bus.pix_valid, 1'b0);
    check("rst_cmd_valid", bus.cmd_valid, 1'b0);
    check("rst_proto_err", bus.proto_err, 1'b0);
    check("rst_frame_done", bus.frame_done, 1'b0);
    check("rst_frame_count", bus.frame_count, 16'h0000);
    check("rst_pix_x", bus.pix_x, 9'd0);
    check("rst_pix_rgb", bus.pix_rgb, 16'h0000);
    check("rst_cmd_code", bus.cmd_code, 8'h00);
    check("rst_state", bus.dbg_state, 3'd0);
    check("rst_sc", bus.dbg_sc, 9'd0);
    check("rst_ec", bus.dbg_ec, 9'd511);
    check("rst_ep", bus.dbg_ep, 9'd511);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // latency: pulse lands 3 cycles after the first edge that samples wr high
    clear_logs();
    bus.wr  = 1'b0;
    bus.dcx = 1'b0;
    bus.D   = 8'h2A;
    repeat (3) @(negedge clk);
    bus.wr = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("lat_early", bus.cmd_valid, 1'b0);
    @(posedge clk);
    #1 check("lat_hit", bus.cmd_valid, 1'b1);
    check("lat_code", bus.cmd_code, 8'h2A);
    @(posedge clk);
    #1 check("lat_one_cycle", bus.cmd_valid, 1'b0);
    repeat (2) @(negedge clk);

    // CASET 5..7
    send_data(8'h00); send_data(8'h05); send_data(8'h00); send_data(8'h07);
    check("caset_ncmd", cmd_q.size(), 1);
    check("caset_cmd", cmd_q[0], 9'h02A);
    check("caset_perr", perr_cnt, 0);
    check("caset_sc", bus.dbg_sc, 9'd5);
    check("caset_ec", bus.dbg_ec, 9'd7);
    check("caset_state", bus.dbg_state, 3'd4);

    // PASET 2..3 then RAMWR 6 pixels, frame wraps on the last one
    clear_logs();
    send_quad(8'h2B, 8'h00, 8'h02, 8'h00, 8'h03);
    check("paset_sp", bus.dbg_sp, 9'd2);
    check("paset_ep", bus.dbg_ep, 9'd3);
    send_cmd(8'h2C);
    check("ramwr_state", bus.dbg_state, 3'd3);
    exp_q.push_back(px(1'b0, 5, 2, 16'hF800));
    exp_q.push_back(px(1'b0, 6, 2, 16'hF800));
    exp_q.push_back(px(1'b0, 7, 2, 16'hF800));
    exp_q.push_back(px(1'b0, 5, 3, 16'hF800));
    exp_q.push_back(px(1'b0, 6, 3, 16'hF800));
    exp_q.push_back(px(1'b1, 7, 3, 16'hF800));
    for (int i = 0; i < 6; i++) begin
      send_data(8'hF8);
      send_data(8'h00);
    end
    check_pixels("ramwr_pix");
    check("ramwr_perr", perr_cnt, 0);

    // CASET with end < start clamps end to start
    clear_logs();
    send_quad(8'h2A, 8'h00, 8'h09, 8'h00, 8'h03);
    check("clamp_perr", perr_cnt, 1);
    check("clamp_cmd", cmd_q[0], 9'h02A);
    check("clamp_sc", bus.dbg_sc, 9'd9);
    check("clamp_ec", bus.dbg_ec, 9'd9);

    // dangling high byte in RAMWR
    clear_logs();
    send_cmd(8'h2C);
    send_data(8'hAB);
    send_cmd(8'h2B);
    check_pixels("dangle_pix");
    check("dangle_ncmd", cmd_q.size(), 2);
    check("dangle_cmd0", cmd_q[0], 9'h02C);
    check("dangle_cmd1", cmd_q[1], 9'h12B);
    check("dangle_perr", perr_cnt, 1);

    // partial PASET interrupted keeps the old window; data in SKIP is silent
    clear_logs();
    send_data(8'h00);
    send_data(8'h01);
    send_cmd(8'h00);
    check("partial_cmd", cmd_q[0], 9'h100);
    check("partial_sp", bus.dbg_sp, 9'd2);
    check("partial_ep", bus.dbg_ep, 9'd3);
    check("partial_state", bus.dbg_state, 3'd4);
    send_data(8'h55);
    check("skip_perr", perr_cnt, 1);

    // software reset, then data in IDLE
    clear_logs();
    send_cmd(8'h01);
    check("swrst_state", bus.dbg_state, 3'd0);
    check("swrst_sc", bus.dbg_sc, 9'd0);
    check("swrst_ec", bus.dbg_ec, 9'd511);
    check("swrst_sp", bus.dbg_sp, 9'd0);
    check("swrst_ep", bus.dbg_ep, 9'd511);
    check("swrst_frame_count", bus.frame_count, FC_EN ? 16'd1 : 16'd0);
    send_data(8'h77);
    check("idle_data_perr", perr_cnt, 1);
    check("idle_data_ncmd", cmd_q.size(), 1);

    // hardware reset in the middle of PASET byte 2
    send_cmd(8'h2B);
    send_data(8'h00);
    @(negedge clk);
    bus.wr  = 1'b0;
    bus.dcx = 1'b1;
    bus.D   = 8'h02;
    repeat (3) @(negedge clk);
    bus.wr = 1'b1;
    @(posedge clk);
    #1 nrst = 1'b0;
    repeat (3) @(negedge clk);
    check("hwrst_state", bus.dbg_state, 3'd0);
    check("hwrst_frame_count", bus.frame_count, 16'h0000);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    clear_logs();
    send_cmd(8'h2C);
    send_data(8'h12);
    send_data(8'h34);
    exp_q.push_back(px(1'b0, 0, 0, 16'h1234));
    check_pixels("hwrst_pix");
    check("hwrst_perr", perr_cnt, 0);

    // 1x1 window: every pixel completes a frame
    clear_logs();
    send_quad(8'h2A, 8'h00, 8'h04, 8'h00, 8'h04);
    send_quad(8'h2B, 8'h00, 8'h06, 8'h00, 8'h06);
    send_cmd(8'h2C);
    for (int i = 1; i <= 3; i++) begin
      send_data(8'h00);
      send_data(8'(i));
      exp_q.push_back(px(1'b1, 4, 6, 16'(i)));
    end
    check_pixels("fc_pix");
    check("fc_frame_count", bus.frame_count, FC_EN ? 16'd3 : 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
